// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared types and constants for the chan_mux_scan block.
//   mode_e  - channel selection mode (MANUAL uses sel, SCAN is round-robin)
//   state_e - output register occupancy (EMPTY / FULL)
//   CNT_W   - width of the optional transfer counter
package chan_mux_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req     - per-channel request vector
//   ptr     - channel index where the search starts
//   gnt_vld - some channel is requesting
//   gnt_idx - first requesting channel found from ptr upward, modulo NUM_CH
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic                      gnt_vld,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  int unsigned idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = (32'(ptr) + off) % NUM_CH;
      if (!gnt_vld && req[IdxW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: N-channel sample multiplexer with a single registered output stage.
// Channel choice is either manual (sel) or round-robin over valid channels (scan).
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_data/valid/ready   - per-channel sample inputs; at most one in_ready bit high
//   mode, sel             - 0 = manual (sel picks channel), 1 = scan
//   out_data/ch/valid     - registered sample, its source channel, occupancy
//   out_ready             - downstream accept
//   xfer_cnt              - handshake counter, present only with CHAN_MUX_CNT_EN defined
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic                      mode,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef CHAN_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]          xfer_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]  ch_q, ch_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;

  logic             drain, load_en, cand_vld, grant, is_scan;
  logic [IdxW-1:0]  cand_idx;
  logic             scan_vld;
  logic [IdxW-1:0]  scan_idx;
  logic [WIDTH-1:0] ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (scan_vld),
    .gnt_idx (scan_idx)
  );

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign is_scan   = (mode_e'(mode) == SCAN);

  // Grant decision; in_ready depends only on inputs and state, never on itself.
  always_comb begin
    drain   = out_valid && out_ready;
    load_en = (state_q == EMPTY) || drain;
    if (is_scan) begin
      cand_vld = scan_vld;
      cand_idx = scan_idx;
    end else begin
      cand_idx = sel;
      // sel beyond the last channel never grants (possible when NUM_CH is not a power of 2)
      cand_vld = (32'(sel) < NUM_CH) && in_valid[sel];
    end
    // Held low during reset so no handshake is reported while the output is discarded.
    grant    = load_en && cand_vld && !rst;
    in_ready = '0;
    if (grant) begin
      in_ready[cand_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = FULL;
      data_d  = ch_data[cand_idx];
      ch_d    = cand_idx;
      if (is_scan) begin
        ptr_d = (32'(cand_idx) == NUM_CH - 1) ? '0 : cand_idx + IdxW'(1);
      end
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef CHAN_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
